icache_dm_refill: RTL and testbench

- Parametrised direct-mapped, read-only instruction/data cache with an integrated miss-refill controller.
- Sits between the MIPS fetch/load stage (request/response handshake) and the line-wide main-memory model.
- Generalises the fixed 8-line, 4-word cache to configurable depth, line size and address width.
- Adds:
  - a real valid/handshake protocol,
  - a blocking miss FSM that fetches the line itself,
  - synchronous flush,
  - hit/miss counters.

---
 rtl/icache_dm_refill_pkg.sv | 54 +++++
 rtl/icache_dm_refill_if.sv | 40 ++++
 rtl/icache_dm_refill_sat_counter.sv | 33 +++
 rtl/icache_dm_refill.sv | 164 ++++++++++++++++
 tb/tb_icache_dm_refill.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_dm_refill_pkg.sv
// Shared definitions for the direct-mapped refill cache.
//   - state_e   : miss-handling FSM states
//   - off_w/idx_w/tag_w : address field widths derived from the geometry
//   - addr_off/addr_idx/addr_tag/line_base : field extraction on a
//     zero-extended byte address (callers cast the result to field width)
package cache_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_MREQ,
        S_MWAIT
    } state_e;

    // Field helpers operate on a wide container so one set of functions
    // serves every ADDR_W up to this limit.
    localparam int unsigned XADDR_W = 64;
    typedef logic [XADDR_W-1:0] xaddr_t;

    function automatic int unsigned off_w(input int unsigned words);
        return $clog2(words);
    endfunction

    function automatic int unsigned idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w,
                                          input int unsigned lines,
                                          input int unsigned words);
        return addr_w - idx_w(lines) - off_w(words) - 2;
    endfunction

    // Word offset within the line (byte bits [1:0] dropped).
    function automatic xaddr_t addr_off(input xaddr_t a, input int unsigned words);
        return (a >> 2) & xaddr_t'(words - 1);
    endfunction

    function automatic xaddr_t addr_idx(input xaddr_t a, input int unsigned lines,
                                        input int unsigned words);
        return (a >> (2 + off_w(words))) & xaddr_t'(lines - 1);
    endfunction

    function automatic xaddr_t addr_tag(input xaddr_t a, input int unsigned lines,
                                        input int unsigned words);
        return a >> (2 + off_w(words) + idx_w(lines));
    endfunction

    // Address with offset and byte bits cleared.
    function automatic xaddr_t line_base(input xaddr_t a, input int unsigned words);
        return a & ~xaddr_t'((words << 2) - 1);
    endfunction

endpackage

// File: rtl/icache_dm_refill_if.sv
// Bus bundle between the CPU fetch/load stage, the cache and the
// line-wide memory model.
//   CPU side   : req_valid/req_addr/req_ready, resp_valid/resp_data/resp_hit
//   Memory side: mem_req_valid/mem_req_addr/mem_req_ready,
//                mem_resp_valid/mem_resp_data
//   Control    : flush; statistics hit_cnt/miss_cnt
// Modports: slave = cache view, master = environment (CPU + memory) view.
interface icache_dm_refill_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned CNT_W  = 16
);
    logic                      req_valid;
    logic [ADDR_W-1:0]         req_addr;
    logic                      req_ready;
    logic                      resp_valid;
    logic [WORD_W-1:0]         resp_data;
    logic                      resp_hit;
    logic                      mem_req_valid;
    logic [ADDR_W-1:0]         mem_req_addr;
    logic                      mem_req_ready;
    logic                      mem_resp_valid;
    logic [WORDS*WORD_W-1:0]   mem_resp_data;
    logic                      flush;
    logic [CNT_W-1:0]          hit_cnt;
    logic [CNT_W-1:0]          miss_cnt;

    modport slave (
        input  req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data, flush,
        output req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr,
               hit_cnt, miss_cnt
    );

    modport master (
        output req_valid, req_addr, mem_req_ready, mem_resp_valid, mem_resp_data, flush,
        input  req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr,
               hit_cnt, miss_cnt
    );
endinterface

// File: rtl/icache_dm_refill_sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset (count -> 0)
//   inc_i  : increment request
//   cnt_o  : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/icache_dm_refill.sv
// Direct-mapped read-only cache with a blocking miss-refill controller.
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset (valid bits, FSM, outputs, counters)
//   bus   : icache_dm_refill_if.slave
//           CPU request/response, line-fill request/response, flush,
//           saturating hit/miss counters
// Only the valid bits are reset; tag and data arrays are plain storage.
module icache_dm_refill
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned LINES  = 8,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input logic             clk,
    input logic             rst_n,
    icache_dm_refill_if.slave bus
);
    localparam int unsigned OFF_W  = off_w(WORDS);
    localparam int unsigned IDX_W  = idx_w(LINES);
    localparam int unsigned TAG_W  = tag_w(ADDR_W, LINES, WORDS);
    localparam int unsigned LINE_W = WORDS * WORD_W;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [LINE_W-1:0]   data_q [LINES];

    logic                req_ready_q;
    logic                resp_valid_q;
    logic                resp_hit_q;
    logic [WORD_W-1:0]   resp_data_q;
    logic                mem_req_valid_q;
    logic [ADDR_W-1:0]   mem_req_addr_q;

    xaddr_t              addr_x;
    logic [OFF_W-1:0]    off;
    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic [ADDR_W-1:0]   line_addr;
    logic                hit;
    logic                fill;
    logic [WORD_W-1:0]   hit_word;
    logic [WORD_W-1:0]   fill_word;
    logic                hit_inc;
    logic                miss_inc;
    logic [CNT_W-1:0]    hit_cnt_w;
    logic [CNT_W-1:0]    miss_cnt_w;

    assign addr_x    = xaddr_t'(addr_q);
    assign off       = OFF_W'(addr_off(addr_x, WORDS));
    assign idx       = IDX_W'(addr_idx(addr_x, LINES, WORDS));
    assign tag       = TAG_W'(addr_tag(addr_x, LINES, WORDS));
    assign line_addr = ADDR_W'(line_base(addr_x, WORDS));

    // A flush in the lookup cycle forces a miss.
    assign hit      = valid_q[idx] && (tag_q[idx] == tag) && !bus.flush;
    assign fill     = (state_q == S_MWAIT) && bus.mem_resp_valid;
    assign hit_inc  = (state_q == S_LOOKUP) && hit;
    assign miss_inc = (state_q == S_LOOKUP) && !hit;

    always_comb begin
        hit_word  = '0;
        fill_word = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (off == OFF_W'(w)) begin
                hit_word  = data_q[idx][w*WORD_W +: WORD_W];
                fill_word = bus.mem_resp_data[w*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            valid_q         <= '0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_hit_q      <= 1'b0;
            resp_data_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            // Clear precedes the fill write below so an in-flight fill
            // still installs its own line after a flush.
            if (bus.flush) begin
                valid_q <= '0;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q      <= bus.req_addr;
                        req_ready_q <= 1'b0;
                        state_q     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b1;
                        resp_data_q  <= hit_word;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        mem_req_valid_q <= 1'b1;
                        mem_req_addr_q  <= line_addr;
                        state_q         <= S_MREQ;
                    end
                end
                S_MREQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= S_MWAIT;
                    end
                end
                S_MWAIT: begin
                    if (bus.mem_resp_valid) begin
                        valid_q[idx] <= 1'b1;
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b0;
                        resp_data_q  <= fill_word;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && fill) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= bus.mem_resp_data;
        end
    end

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .inc_i  (hit_inc),
        .cnt_o  (hit_cnt_w)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .inc_i  (miss_inc),
        .cnt_o  (miss_cnt_w)
    );

    assign bus.req_ready     = req_ready_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_hit      = resp_hit_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
    assign bus.hit_cnt       = hit_cnt_w;
    assign bus.miss_cnt      = miss_cnt_w;
endmodule

// File: tb/tb_icache_dm_refill.sv
// Randomised self-checking bench for icache_dm_refill with a line-address
// level reference model of the cache contents and saturating counters.
module tb_icache_dm_refill;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINES      = 8;
    localparam int unsigned WORDS      = 4;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned LINE_BYTES = WORDS * 4;
    localparam int unsigned CNT_MAX    = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    icache_dm_refill_if #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W),
        .WORDS  (WORDS),
        .CNT_W  (CNT_W)
    ) bus ();

    icache_dm_refill #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W),
        .LINES  (LINES),
        .WORDS  (WORDS),
        .CNT_W  (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks;
    int unsigned errors;

    // Reference model: which line address each set holds, plus counters.
    bit          mv    [LINES];
    logic [31:0] mline [LINES];
    int unsigned mhit;
    int unsigned mmiss;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        logic [31:0] h;
        if (wa[31:4] == 28'h4) begin
            return 32'hA0 + {30'b0, wa[3:2]};
        end
        h = wa * 32'h9E37_79B1;
        return h ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [WORDS*WORD_W-1:0] mem_line(input logic [31:0] base);
        logic [WORDS*WORD_W-1:0] l;
        l = '0;
        for (int w = 0; w < WORDS; w++) begin
            l[w*WORD_W +: WORD_W] = mem_word(base + 32'(w * 4));
        end
        return l;
    endfunction

    function automatic int unsigned sat(input int unsigned v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    endtask

    task automatic check_counters();
        check("hit_cnt",  64'(bus.hit_cnt),  64'(sat(mhit)));
        check("miss_cnt", 64'(bus.miss_cnt), 64'(sat(mmiss)));
    endtask

    // Leaves the bench at a falling edge with the cache idle.
    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        mhit  = 0;
        mmiss = 0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        model_clear();
        check("flush_idle_resp", 64'(bus.resp_valid), 64'(0));
    endtask

    task automatic spurious_fill();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        check("spurious_resp", 64'(bus.resp_valid), 64'(0));
        check("spurious_ready", 64'(bus.req_ready), 64'(1));
    endtask

    // One read transaction, entered and left at a falling edge in IDLE.
    // fmode: 0 none, 1 flush during lookup, 2 flush while requesting memory.
    task automatic do_read(input logic [31:0] addr, input int unsigned rdy_dly,
                           input int unsigned resp_dly, input int unsigned fmode);
        logic [31:0] base;
        int unsigned idx;
        int unsigned off;
        bit          exp_hit;
        logic [31:0] exp_data;

        base     = addr - (addr % LINE_BYTES);
        idx      = (addr / LINE_BYTES) % LINES;
        off      = (addr % LINE_BYTES) / 4;
        exp_hit  = (fmode != 1) && mv[idx] && (mline[idx] == base);
        exp_data = mem_word(base + 32'(off * 4));

        check("req_ready_idle", 64'(bus.req_ready), 64'(1));
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        check("req_ready_busy", 64'(bus.req_ready), 64'(0));
        check("resp_early", 64'(bus.resp_valid), 64'(0));
        if (fmode == 1) bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        if (fmode != 0) model_clear();

        if (exp_hit) begin
            mhit++;
            check("hit_resp_valid", 64'(bus.resp_valid), 64'(1));
            check("hit_resp_hit", 64'(bus.resp_hit), 64'(1));
            check("hit_resp_data", 64'(bus.resp_data), 64'(exp_data));
            check("hit_no_memreq", 64'(bus.mem_req_valid), 64'(0));
        end else begin
            mmiss++;
            check("miss_no_resp", 64'(bus.resp_valid), 64'(0));
            check("memreq_valid", 64'(bus.mem_req_valid), 64'(1));
            check("memreq_addr", 64'(bus.mem_req_addr), 64'(base));
            if (fmode == 2) bus.flush = 1'b1;
            for (int i = 0; i < int'(rdy_dly); i++) begin
                @(negedge clk);
                bus.flush = 1'b0;
                check("memreq_hold_valid", 64'(bus.mem_req_valid), 64'(1));
                check("memreq_hold_addr", 64'(bus.mem_req_addr), 64'(base));
                check("memreq_hold_ready", 64'(bus.req_ready), 64'(0));
            end
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            bus.mem_req_ready = 1'b0;
            bus.flush         = 1'b0;
            check("memreq_drop", 64'(bus.mem_req_valid), 64'(0));
            for (int i = 0; i < int'(resp_dly); i++) begin
                check("mwait_no_resp", 64'(bus.resp_valid), 64'(0));
                @(negedge clk);
            end
            check("mwait_no_resp", 64'(bus.resp_valid), 64'(0));
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = mem_line(base);
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
            check("fill_resp_valid", 64'(bus.resp_valid), 64'(1));
            check("fill_resp_hit", 64'(bus.resp_hit), 64'(0));
            check("fill_resp_data", 64'(bus.resp_data), 64'(exp_data));
            mv[idx]    = 1'b1;
            mline[idx] = base;
        end
        check_counters();
        @(negedge clk);
        check("resp_pulse", 64'(bus.resp_valid), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no end, expected end of test");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        checks             = 0;
        errors             = 0;
        rst_n              = 1'b0;
        bus.req_valid      = 1'b0;
        bus.req_addr       = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.flush          = 1'b0;
        @(negedge clk);
        do_reset();

        check("rst_req_ready", 64'(bus.req_ready), 64'(1));
        check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("rst_resp_hit", 64'(bus.resp_hit), 64'(0));
        check("rst_resp_data", 64'(bus.resp_data), 64'(0));
        check("rst_memreq_valid", 64'(bus.mem_req_valid), 64'(0));
        check("rst_memreq_addr", 64'(bus.mem_req_addr), 64'(0));
        check("rst_hit_cnt", 64'(bus.hit_cnt), 64'(0));
        check("rst_miss_cnt", 64'(bus.miss_cnt), 64'(0));

        // Cold miss, then a same-line hit issued back to back.
        do_read(32'h0000_0048, 1, 1, 0);
        check("cold_miss_cnt", 64'(bus.miss_cnt), 64'(1));
        do_read(32'h0000_004C, 0, 0, 0);
        check("hit_cnt_one", 64'(bus.hit_cnt), 64'(1));

        // Memory back-pressure for five cycles.
        do_read(32'h0000_0104, 5, 2, 0);

        // Flush after a fill: the re-read misses.
        do_flush();
        do_read(32'h0000_004C, 0, 0, 0);

        // Conflict eviction on index 4.
        do_reset();
        do_read(32'h0000_0040, 0, 1, 0);
        do_read(32'h0000_00C0, 2, 0, 0);
        do_read(32'h0000_0040, 1, 0, 0);
        check("conflict_miss_cnt", 64'(bus.miss_cnt), 64'(3));
        check("conflict_hit_cnt", 64'(bus.hit_cnt), 64'(0));

        // Reset while waiting for the fill; the late fill must be ignored.
        do_reset();
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000_0048;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("rstfill_memreq", 64'(bus.mem_req_valid), 64'(1));
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        mhit  = 0;
        mmiss = 0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = mem_line(32'h0000_0040);
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstfill_no_resp", 64'(bus.resp_valid), 64'(0));
            check("rstfill_no_memreq", 64'(bus.mem_req_valid), 64'(0));
            @(negedge clk);
        end
        check("rstfill_hit_cnt", 64'(bus.hit_cnt), 64'(0));
        check("rstfill_miss_cnt", 64'(bus.miss_cnt), 64'(0));
        do_read(32'h0000_0048, 0, 0, 0);

        // Saturation: nine hits on a three-bit counter.
        do_reset();
        do_read(32'h0000_0040, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            do_read(32'h0000_0040 + 32'((i % 4) * 4), 0, 0, 0);
        end
        check("hit_saturated", 64'(bus.hit_cnt), 64'(7));
        check("miss_after_sat", 64'(bus.miss_cnt), 64'(1));

        // Randomised traffic over a small address pool to mix hits, misses,
        // conflicts, flushes and stray fill strobes.
        do_reset();
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            int unsigned fm;
            if (n == 100) do_reset();
            a = 32'(($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4)
                    | $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
            fm = $urandom_range(0, 19);
            if ($urandom_range(0, 15) == 0) do_flush();
            if ($urandom_range(0, 15) == 0) spurious_fill();
            do_read(a, $urandom_range(0, 4), $urandom_range(0, 3),
                    (fm == 0) ? 1 : ((fm == 1) ? 2 : 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
